// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - states, segment patterns and digit limit shared by stopwatch_counter
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  // Active-low a..g in bits 0..6, dp (bit 7) held off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/sseg_encoder.sv
// rtl/sseg_encoder.sv - combinational BCD digit to active-low seven-segment pattern
module sseg_encoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - 00.00..99.99 stopwatch; STOPWATCH_SATURATE_EN selects saturate-and-pause at 99.99
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic       running,
  output logic       ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

`ifdef STOPWATCH_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  sw_state_t     state, state_nxt;
  logic [PW-1:0] presc;
  logic [3:0]    dig     [4];
  logic [3:0]    dig_nxt [4];
  logic [7:0]    seg_enc [4];
  logic          tick, at_max, carry;

  assign tick   = (state == ST_RUN) && (presc == PRESC_LAST);
  assign at_max = (dig[0] == DIGIT_MAX) && (dig[1] == DIGIT_MAX) &&
                  (dig[2] == DIGIT_MAX) && (dig[3] == DIGIT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      if (start_stop) begin
        case (state)
          ST_IDLE:  state_nxt = ST_RUN;
          ST_RUN:   state_nxt = ST_PAUSE;
          default:  state_nxt = ST_RUN;
        endcase
      end
      if (SATURATE && tick && at_max) state_nxt = ST_PAUSE;
    end
  end

  // Decimal cascade: each digit wraps 9->0 and passes the carry upward
  always_comb begin
    carry = tick && !(SATURATE && at_max);
    for (int i = 0; i < 4; i++) begin
      dig_nxt[i] = dig[i];
      if (carry) begin
        if (dig[i] >= DIGIT_MAX) begin
          dig_nxt[i] = 4'd0;
        end else begin
          dig_nxt[i] = dig[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_enc
    sseg_encoder u_enc (
      .bcd (dig[g]),
      .seg (seg_enc[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      ovf     <= 1'b0;
      running <= 1'b0;
      seg0    <= SEG_0;
      seg1    <= SEG_0;
      seg2    <= SEG_0;
      seg3    <= SEG_0;
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
    end else begin
      running <= (state_nxt == ST_RUN);
      seg0    <= seg_enc[0];
      seg1    <= seg_enc[1];
      seg2    <= seg_enc[2];
      seg3    <= seg_enc[3];
      if (clear) begin
        presc <= '0;
        ovf   <= 1'b0;
        for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
      end else begin
        // Prescaler holds outside RUN so a resume keeps the partial tick
        if (state == ST_RUN) presc <= tick ? '0 : presc + PW'(1);
        if (tick && at_max) ovf <= 1'b1;
        for (int i = 0; i < 4; i++) dig[i] <= dig_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - randomized bench for stopwatch_counter; expectations follow STOPWATCH_SATURATE_EN
module tb_stopwatch_counter;

  localparam int TD = 4;
`ifdef STOPWATCH_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, start_stop = 1'b0, clear = 1'b0;
  logic [7:0] seg0, seg1, seg2, seg3;
  logic       running, ovf;
  int         total = 0, bad = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} mode_t;
  mode_t m_mode;
  int    m_cnt, m_prev, m_pre;
  bit    m_ovf;
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  stopwatch_counter #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .seg0       (seg0),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .running    (running),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] observed();
    return {seg3, seg2, seg1, seg0, running, ovf};
  endfunction

  // Displays show the hundredths count as it stood one edge earlier
  function automatic logic [33:0] expected();
    return {seg_tab[(m_prev / 1000) % 10], seg_tab[(m_prev / 100) % 10],
            seg_tab[(m_prev / 10) % 10], seg_tab[m_prev % 10],
            (m_mode == M_RUN), m_ovf};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_prev = 0; m_pre = 0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input bit ss, input bit clr);
    bit    tk;
    mode_t nm;
    m_prev = m_cnt;
    if (clr) begin
      model_reset();
      m_prev = m_cnt == 0 ? m_prev : 0;
    end else begin
      tk = (m_mode == M_RUN) && (m_pre == TD - 1);
      nm = m_mode;
      if (ss) nm = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
      if (m_mode == M_RUN) m_pre = tk ? 0 : m_pre + 1;
      if (tk) begin
        if (m_cnt == 9999) begin
          m_ovf = 1'b1;
          if (SAT) nm = M_PAUSE;
          else     m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      m_mode = nm;
    end
  endtask

  task automatic cycle(input bit ss, input bit clr);
    int keep;
    @(negedge clk);
    start_stop = ss;
    clear      = clr;
    @(posedge clk);
    keep = m_cnt;
    model_step(ss, clr);
    if (clr) m_prev = keep;
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (observed() !== expected()) begin
      $display("FAIL reset_hold got=%h exp=%h", observed(), expected()); bad++;
    end
    total++;
    if ({seg3, seg2, seg1, seg0} !== {4{8'hC0}}) begin
      $display("FAIL reset_segs got=%h exp=%h", {seg3, seg2, seg1, seg0}, {4{8'hC0}}); bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0);
      total++;
      if (observed() !== expected()) begin
        $display("FAIL reset_release got=%h exp=%h", observed(), expected()); bad++;
      end
    end
  endtask

  task automatic test_count();
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 41; i++) begin
      cycle(1'b0, 1'b0);
      total++;
      if (observed() !== expected()) begin
        $display("FAIL count_step got=%h exp=%h", observed(), expected()); bad++;
      end
    end
    total++;
    if ({seg3, seg2, seg1, seg0, running} !== {8'hC0, 8'hC0, 8'hF9, 8'hC0, 1'b1}) begin
      $display("FAIL count_0010 got=%h exp=%h", {seg3, seg2, seg1, seg0, running},
               {8'hC0, 8'hC0, 8'hF9, 8'hC0, 1'b1});
      bad++;
    end
  endtask

  task automatic test_pause_resume();
    logic [7:0] s0;
    int lat;
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 8 && m_pre != 1; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      total++;
      if (observed() !== expected()) begin
        $display("FAIL pause_hold got=%h exp=%h", observed(), expected()); bad++;
      end
    end
    s0  = seg0;
    lat = 0;
    cycle(1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 1'b0);
      if (lat == 0 && seg0 !== s0) lat = k;
      total++;
      if (observed() !== expected()) begin
        $display("FAIL resume_step got=%h exp=%h", observed(), expected()); bad++;
      end
    end
    total++;
    if (lat !== 3) begin
      $display("FAIL resume_latency got=%0d exp=%0d", lat, 3); bad++;
    end
  endtask

  task automatic test_overflow();
    logic [33:0] exp_v;
    int guard;
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    guard = 0;
    while (m_cnt != 9999 && guard < 45000) begin
      cycle(1'b0, 1'b0);
      guard++;
      total++;
      if (observed() !== expected()) begin
        $display("FAIL run_to_max got=%h exp=%h", observed(), expected()); bad++;
      end
    end
    if (m_cnt != 9999) begin
      total++; bad++;
      $display("FAIL run_to_max_timeout got=%0d exp=%0d", m_cnt, 9999);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      total++;
      if (observed() !== expected()) begin
        $display("FAIL wrap_step got=%h exp=%h", observed(), expected()); bad++;
      end
    end
`ifdef STOPWATCH_SATURATE_EN
    exp_v = {{4{8'h90}}, 1'b0, 1'b1};
`else
    exp_v = {{4{8'hC0}}, 1'b1, 1'b1};
`endif
    total++;
    if (observed() !== exp_v) begin
      $display("FAIL overflow_result got=%h exp=%h", observed(), exp_v); bad++;
    end
  endtask

  task automatic test_clear_priority();
    if (m_mode != M_RUN) cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    total++;
    if (running !== 1'b0 || observed() !== expected()) begin
      $display("FAIL clear_wins got=%h exp=%h", observed(), expected()); bad++;
    end
    cycle(1'b0, 1'b0);
    total++;
    if (observed() !== {{4{8'hC0}}, 1'b0, 1'b0}) begin
      $display("FAIL clear_idle got=%h exp=%h", observed(), {{4{8'hC0}}, 1'b0, 1'b0}); bad++;
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (observed() !== {{4{8'hC0}}, 1'b0, 1'b0}) begin
      $display("FAIL async_reset got=%h exp=%h", observed(), {{4{8'hC0}}, 1'b0, 1'b0}); bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      cycle(1'b0, 1'b0);
      total++;
      if (observed() !== expected()) begin
        $display("FAIL async_release got=%h exp=%h", observed(), expected()); bad++;
      end
    end
  endtask

  task automatic test_random();
    bit ss, clr;
    for (int i = 0; i < 2000; i++) begin
      ss  = ($urandom_range(7) == 0);
      clr = ($urandom_range(49) == 0);
      cycle(ss, clr);
      total++;
      if (observed() !== expected()) begin
        $display("FAIL random_step got=%h exp=%h ss=%0b clr=%0b", observed(), expected(), ss, clr);
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_pause_resume();
    test_overflow();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
